// File: rtl/cache_miss_ctrl.sv
// Miss controller: optional dirty write-back, then line allocate, then a one-cycle fill pulse. Optional CACHE_MISS_CTRL_TIMEOUT_EN adds a sticky wait timeout.
// Clean miss fills 2 cycles after req_valid is sampled. Holds mem_req_* until mem_ready, and pipe_en stalls the pipeline while busy.
module cache_miss_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_dirty,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [LINE_W-1:0] victim_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic              pipe_en,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WB, ALLOC, DONE} state_t;

  state_t            state, state_nxt;
  logic              timeout;
  logic [ADDR_W-1:0] cap_req_addr;
  logic [ADDR_W-1:0] cap_victim_addr;
  logic [LINE_W-1:0] cap_victim_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_dirty ? WB : ALLOC;
      WB:      if (timeout) state_nxt = IDLE; else if (mem_ready) state_nxt = ALLOC;
      ALLOC:   if (timeout) state_nxt = IDLE; else if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    fill_valid    = 1'b0;
    case (state)
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = cap_victim_addr;
        mem_req_wdata = cap_victim_data;
      end
      ALLOC: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = cap_req_addr;
      end
      DONE:    fill_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state != IDLE);
  assign pipe_en = (state == IDLE) && !req_valid;

  // Request fields are only sampled on the accepting edge, so later changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_req_addr    <= '0;
      cap_victim_addr <= '0;
      cap_victim_data <= '0;
    end else if (state == IDLE && req_valid) begin
      cap_req_addr    <= req_addr;
      cap_victim_addr <= victim_addr;
      cap_victim_data <= victim_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           fill_data <= '0;
    else if (state == ALLOC && mem_ready) fill_data <= mem_rdata;
  end

`ifdef CACHE_MISS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             waiting;

  assign waiting = (state == WB || state == ALLOC) && !mem_ready;
  // The Nth stalled cycle is the one that trips, so compare against N-1.
  assign timeout = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_nxt == WB || state_nxt == ALLOC) && state_nxt != state) wait_cnt <= '0;
      else if (waiting)                                                   wait_cnt <= wait_cnt + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign err                = 1'b0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: table vectors plus random misses against a per-cycle expected-trace model.
// Define CACHE_MISS_CTRL_TIMEOUT_EN to also exercise the timeout path with TIMEOUT_CYCLES=8.
module tb_cache_miss_ctrl;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_dirty;
  logic [AW-1:0] req_addr, victim_addr;
  logic [LW-1:0] victim_data;
  logic          mem_req_valid, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;
  logic          fill_valid;
  logic [LW-1:0] fill_data;
  logic          pipe_en, busy, err;

  int            tests = 0;
  int            fails = 0;
  logic [LW-1:0] last_fill;

  cache_miss_ctrl #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_dirty(req_dirty),
    .req_addr(req_addr), .victim_addr(victim_addr), .victim_data(victim_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_data(fill_data), .pipe_en(pipe_en), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Random request-side noise while the controller is busy; it must all be ignored.
  task automatic garbage();
    req_valid   = 1'($urandom_range(0, 1));
    req_dirty   = 1'($urandom_range(0, 1));
    req_addr    = $urandom;
    victim_addr = $urandom;
    victim_data = rnd_line();
  endtask

  typedef struct {
    logic          mv;
    logic          rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
    logic          fv;
    logic          rdy;
    logic          rd_done;
  } cyc_t;

  // Entered just after a rising edge with the DUT idle; leaves it the same way.
  task automatic run_miss(input logic dirty, input logic [AW-1:0] ra, input logic [AW-1:0] va,
                          input logic [LW-1:0] vd, input logic [LW-1:0] rd,
                          input int wbw, input int alw, input int exp_lat, input string tag);
    cyc_t tr[$];
    cyc_t c;
    int   fill_at = -1;
    if (dirty)
      for (int i = 0; i <= wbw; i++) begin
        c = '{1'b1, 1'b1, va, vd, 1'b0, (i == wbw), 1'b0};
        tr.push_back(c);
      end
    for (int i = 0; i <= alw; i++) begin
      c = '{1'b1, 1'b0, ra, '0, 1'b0, (i == alw), (i == alw)};
      tr.push_back(c);
    end
    c = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0};
    tr.push_back(c);

    req_valid = 1'b1; req_dirty = dirty; req_addr = ra; victim_addr = va; victim_data = vd;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = rnd_line();
    @(negedge clk);
    chk1({tag, " pipe_en on request"}, pipe_en, 1'b0);
    chk1({tag, " busy on request"}, busy, 1'b0);
    @(posedge clk); #1;
    foreach (tr[j]) begin
      garbage();
      mem_ready = tr[j].rdy;
      mem_rdata = tr[j].rd_done ? rd : rnd_line();
      @(negedge clk);
      chk1({tag, " mem_req_valid"}, mem_req_valid, tr[j].mv);
      if (tr[j].mv) begin
        chk1({tag, " mem_req_rw"}, mem_req_rw, tr[j].rw);
        chkw({tag, " mem_req_addr"}, LW'(mem_req_addr), LW'(tr[j].addr));
      end
      chkw({tag, " mem_req_wdata"}, mem_req_wdata, tr[j].wd);
      chk1({tag, " fill_valid"}, fill_valid, tr[j].fv);
      chk1({tag, " busy"}, busy, 1'b1);
      chk1({tag, " pipe_en"}, pipe_en, 1'b0);
      if (fill_valid && fill_at < 0) fill_at = j + 1;
      if (tr[j].fv) last_fill = rd;
      chkw({tag, " fill_data"}, fill_data, last_fill);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk1({tag, " busy after"}, busy, 1'b0);
    chk1({tag, " pipe_en after"}, pipe_en, 1'b1);
    chk1({tag, " mem_req_valid after"}, mem_req_valid, 1'b0);
    chk1({tag, " fill_valid after"}, fill_valid, 1'b0);
    chkw({tag, " fill_data hold"}, fill_data, last_fill);
    chkw({tag, " latency"}, LW'(fill_at), LW'(exp_lat));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          dirty;
    logic [AW-1:0] ra;
    logic [AW-1:0] va;
    logic [LW-1:0] vd;
    logic [LW-1:0] rd;
    int            wbw;
    int            alw;
    int            lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int lat, fcnt;
    logic dirty;
    int wbw, alw;

    vt[0] = '{1'b0, 32'h1000, 32'h0,    '0,            {16{8'hA5}}, 0, 0, 2};
    vt[1] = '{1'b1, 32'h3000, 32'h2000, {16{8'h11}},   {16{8'h5C}}, 3, 0, 6};
    vt[2] = '{1'b0, 32'h0040, 32'h9000, {16{8'hFF}},   {16{8'h3C}}, 0, 2, 4};
    vt[3] = '{1'b1, 32'hFFF0, 32'h0010, {16{8'h77}},   {16{8'h00}}, 0, 1, 4};
    vt[4] = '{1'b1, 32'h8000, 32'h7FF0, {16{8'hC3}},   {16{8'h96}}, 2, 3, 8};

    reset = 1'b1; req_valid = 1'b0; req_dirty = 1'b0; req_addr = '0; victim_addr = '0;
    victim_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    last_fill = '0;
    #12;
    chk1("reset busy", busy, 1'b0);
    chk1("reset mem_req_valid", mem_req_valid, 1'b0);
    chk1("reset fill_valid", fill_valid, 1'b0);
    chk1("reset err", err, 1'b0);
    chkw("reset fill_data", fill_data, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vt[i])
      run_miss(vt[i].dirty, vt[i].ra, vt[i].va, vt[i].vd, vt[i].rd,
               vt[i].wbw, vt[i].alw, vt[i].lat, $sformatf("vec%0d", i));

    for (int n = 0; n < 25; n++) begin
      dirty = 1'($urandom_range(0, 1));
      wbw   = $urandom_range(0, 4);
      alw   = $urandom_range(0, 4);
      lat   = 2 + alw + (dirty ? wbw + 1 : 0);
      run_miss(dirty, $urandom, $urandom, rnd_line(), rnd_line(), wbw, alw, lat,
               $sformatf("rnd%0d", n));
    end

    // req_valid held high: a new miss is only accepted once IDLE is seen again.
    req_valid = 1'b1; req_dirty = 1'b0; req_addr = 32'h4000;
    mem_ready = 1'b1; mem_rdata = {16{8'h4B}};
    fcnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1($sformatf("b2b busy c%0d", c), busy, (c % 3) != 0);
      chk1($sformatf("b2b fill c%0d", c), fill_valid, (c % 3) == 2);
      chk1($sformatf("b2b pipe_en c%0d", c), pipe_en, 1'b0);
      if (fill_valid) fcnt++;
    end
    chkw("b2b fill count", LW'(fcnt), LW'(3));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    last_fill = {16{8'h4B}};
    @(negedge clk);
    chk1("b2b drained", busy, 1'b0);
    chkw("b2b fill_data", fill_data, last_fill);
    @(posedge clk); #1;

    // Reset while ALLOC is stalled drops the transfer at once.
    req_valid = 1'b1; req_dirty = 1'b0; req_addr = 32'h5000;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk1("rst mid mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst mid busy", busy, 1'b0);
    chk1("rst mid fill_valid", fill_valid, 1'b0);
    chkw("rst mid fill_data", fill_data, '0);
    last_fill = '0;
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("rst after fill_valid", fill_valid, 1'b0);
      chk1("rst after busy", busy, 1'b0);
      @(posedge clk); #1;
    end

`ifdef CACHE_MISS_CTRL_TIMEOUT_EN
    req_valid = 1'b1; req_dirty = 1'b0; req_addr = 32'h6000;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      chk1($sformatf("to wait busy c%0d", c), busy, 1'b1);
      chk1($sformatf("to wait err c%0d", c), err, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("to err set", err, 1'b1);
    chk1("to idle", busy, 1'b0);
    chk1("to no fill", fill_valid, 1'b0);
    chk1("to mem_req_valid", mem_req_valid, 1'b0);
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1("to err sticky", err, 1'b1);
      chk1("to no late fill", fill_valid, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk1("to err cleared", err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
`else
    req_valid = 1'b1; req_dirty = 1'b0; req_addr = 32'h6000;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk1($sformatf("wait busy c%0d", c), busy, 1'b1);
      chk1($sformatf("wait err c%0d", c), err, 1'b0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; mem_rdata = {16{8'hD2}};
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk1("long wait fill", fill_valid, 1'b1);
    chkw("long wait fill_data", fill_data, {16{8'hD2}});
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
